uart_rx_word_assembler: RTL and testbench
=========================================

Name: uart_rx_word_assembler

Overview:
Receive-side counterpart of the UART word transmitter. It deserialises 8N1 UART frames from a serial line and reassembles the 5-byte word protocol into one 32-bit word. The protocol is 4 data bytes, most-significant byte first, followed by a 0x0A newline terminator. The block sits between the board RX pin and the CPU memory-mapped read path, and presents each completed word with a valid/acknowledge handshake.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200 baud); legal range is 4 or more.
TERM_BYTE, 8'h0A, terminator byte that closes each word.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
rx_serial  input  1  asynchronous UART line, idle high
rd_ack  input  1  consumer has taken word_data; sampled only while word_valid=1
word_data  output  32  last completed word, byte0 in [31:24]
word_valid  output  1  word_data holds an unread word
frame_err  output  1  one-cycle pulse on a protocol or framing error
overrun  output  1  one-cycle pulse when a completed word is dropped

Behaviour:
- Reset, asserted asynchronously: word_data=0, word_valid=0, frame_err=0, overrun=0. Byte count=0, bit FSM=IDLE, synchroniser flops=1. Reset mid-frame discards all partial data.
- rx_serial passes through a 2-flop synchroniser; all logic uses the synchronised value rx_s.
- Bit FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: when rx_s=0, clear the baud counter and go to START.
  - START: at count CLKS_PER_BIT/2 - 1 (integer division), re-check rx_s.
    - rx_s=0: clear the counter and go to DATA.
    - rx_s=1: treat as a glitch and return to IDLE. No error.
  - DATA: sample rx_s every CLKS_PER_BIT cycles. There are 8 samples, LSB first, each shifted into the byte register. After the 8th sample go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - rx_s=1: the byte is good and is handed to the assembler. Go to IDLE.
    - rx_s=0: pulse frame_err, discard the byte, reset the byte count to 0, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s=1, then go to IDLE.
- Assembler, acting on each good byte with byte count c (0..4):
  - c<4 and byte≠TERM_BYTE: shift the byte into the 32-bit assembly register (new byte enters [7:0], older bytes move up); c=c+1.
  - c<4 and byte==TERM_BYTE: pulse frame_err, set c=0, discard the assembly register. The terminator is the resync point.
  - c==4 and byte==TERM_BYTE: the word completes, then c=0.
  - c==4 and byte≠TERM_BYTE: pulse frame_err, set c=0, discard.
- Word completion takes effect on the cycle after the terminator's stop-bit sample:
  - word_valid=0, or word_valid=1 with rd_ack=1 in the same cycle: word_data is loaded and word_valid=1. No overrun.
  - word_valid=1 and rd_ack=0: the new word is dropped, word_data is unchanged, and overrun pulses for 1 cycle.
- Handshake:
  - rd_ack=1 while word_valid=1 with no simultaneous completion clears word_valid on the next edge. word_data holds its value.
  - rd_ack while word_valid=0 is ignored.
- frame_err and overrun never assert in the same cycle. Each is exactly 1 cycle wide per event.
- Baud counter width is $clog2(CLKS_PER_BIT). There is no inter-frame gap requirement; back-to-back frames are accepted.

Test Plan:
All tests use CLKS_PER_BIT=16 and drive rx_serial with an ideal 8N1 bench transmitter.
1. Reset, then send bytes F0 F0 F0 F0 0A back-to-back -> word_valid=1 and word_data=32'hF0F0F0F0, asserted 1 cycle after the 5th stop-bit sample plus 2 synchroniser cycles. frame_err and overrun stay 0. Pulse rd_ack -> word_valid=0 on the next cycle.
2. Send DE AD BE EF 0A, no ack, then 01 02 03 04 0A -> word_data stays 32'hDEADBEEF, word_valid stays 1, overrun pulses once. Then ack while a third word 11 22 33 44 0A completes in the same cycle -> word_data=32'h11223344, word_valid stays 1, no overrun.
3. Send 12 34 0A -> frame_err pulses once, no word. Then send 12 34 56 78 0A -> word_data=32'h12345678.
4. Send 12 34 56 78 55 -> frame_err pulses and nothing is stored. Then 0A (c=0, treated as terminator) -> another frame_err pulse. Then AA BB CC DD 0A -> word_data=32'hAABBCCDD.
5. Drive stop bit=0 on byte 2, hold the line low for 40 cycles, then release and send a full word 01 23 45 67 0A -> one frame_err pulse, and word_data=32'h01234567 only after recovery.
6. Drive a 5-cycle low glitch while idle -> no error and no state change. Assert rst_n=0 during byte 3 of a word, release, send CA FE BA BE 0A -> word_data=32'hCAFEBABE with no residue from the aborted word.

Source files
------------

// File: rtl/uart_rx_word_assembler.sv
// 8N1 UART receiver that rebuilds 32-bit words from 4 data bytes + terminator.
// Ports: clk, rst_n, rx_serial, rd_ack in; word_data, word_valid, frame_err, overrun out.
module uart_rx_word_assembler #(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [7:0]  TERM_BYTE    = 8'h0A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_serial,
  input  logic        rd_ack,
  output logic [31:0] word_data,
  output logic        word_valid,
  output logic        frame_err,
  output logic        overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  logic          rx_meta_q;
  logic          rx_s_q;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          byte_vld_q, byte_vld_d;
  logic          stop_err;

  logic [31:0]   asm_q, asm_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic          asm_err;
  logic          complete;

  logic [31:0]   word_q, word_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ovr_q, ovr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_serial;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    byte_vld_d = 1'b0;
    stop_err   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d = '0;
          bit_d = '0;
          // A high line at mid start bit is a glitch.
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          shreg_d = {rx_s_q, shreg_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (rx_s_q) begin
            byte_vld_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            stop_err = 1'b1;
            state_d  = S_WAIT;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // shreg_q stays stable after the stop sample, so the
  // assembler reads it one cycle later alongside byte_vld_q.
  always_comb begin
    asm_d    = asm_q;
    bcnt_d   = bcnt_q;
    asm_err  = 1'b0;
    complete = 1'b0;
    if (stop_err) begin
      bcnt_d = '0;
      asm_d  = '0;
    end else if (byte_vld_q) begin
      if (bcnt_q != 3'd4) begin
        if (shreg_q == TERM_BYTE) begin
          asm_err = 1'b1;
          bcnt_d  = '0;
          asm_d   = '0;
        end else begin
          asm_d  = {asm_q[23:0], shreg_q};
          bcnt_d = bcnt_q + 1'b1;
        end
      end else begin
        bcnt_d = '0;
        if (shreg_q == TERM_BYTE) begin
          complete = 1'b1;
        end else begin
          asm_err = 1'b1;
          asm_d   = '0;
        end
      end
    end
  end

  always_comb begin
    word_d  = word_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (complete) begin
      if (!valid_q || rd_ack) begin
        word_d  = asm_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && rd_ack) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      byte_vld_q <= 1'b0;
      asm_q      <= '0;
      bcnt_q     <= '0;
      word_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      byte_vld_q <= byte_vld_d;
      asm_q      <= asm_d;
      bcnt_q     <= bcnt_d;
      word_q     <= word_d;
      valid_q    <= valid_d;
      ferr_q     <= stop_err | asm_err;
      ovr_q      <= ovr_d;
    end
  end

  assign word_data  = word_q;
  assign word_valid = valid_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_word_assembler.sv
// Directed bench for uart_rx_word_assembler at 16 clocks per bit.
// Ideal 8N1 transmitter; pulse counters track frame_err/overrun.
module tb_uart_rx_word_assembler;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_serial;
  logic        rd_ack;
  logic [31:0] word_data;
  logic        word_valid;
  logic        frame_err;
  logic        overrun;

  int n_chk  = 0;
  int n_fail = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int both_cnt = 0;

  uart_rx_word_assembler #(
    .CLKS_PER_BIT(CPB),
    .TERM_BYTE   (8'h0A)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_serial (rx_serial),
    .rd_ack    (rd_ack),
    .word_data (word_data),
    .word_valid(word_valid),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
    if (frame_err && overrun) both_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tx(input logic [7:0] b, input logic sb);
    rx_serial = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_serial = sb;
    repeat (CPB) @(negedge clk);
    rx_serial = 1'b1;
  endtask

  task automatic tx_word(input logic [31:0] w);
    tx(w[31:24], 1'b1);
    tx(w[23:16], 1'b1);
    tx(w[15:8], 1'b1);
    tx(w[7:0], 1'b1);
    tx(8'h0A, 1'b1);
  endtask

  task automatic ack;
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    chk("ack_clears_valid", {31'd0, word_valid}, 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    rx_serial = 1'b1;
    rd_ack    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", word_data, 32'd0);
    chk("rst_valid", {31'd0, word_valid}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: basic word with exact completion latency
    tx(8'hF0, 1'b1);
    tx(8'hF0, 1'b1);
    tx(8'hF0, 1'b1);
    tx(8'hF0, 1'b1);
    fork
      tx(8'h0A, 1'b1);
      begin
        repeat (155) @(negedge clk);
        chk("t1_not_yet", {31'd0, word_valid}, 32'd0);
        @(negedge clk);
        chk("t1_valid_edge", {31'd0, word_valid}, 32'd1);
        chk("t1_data", word_data, 32'hF0F0F0F0);
      end
    join
    chk("t1_ferr", ferr_cnt, 0);
    chk("t1_ovr", ovr_cnt, 0);
    ack();

    // 2: overrun, then ack coincident with completion
    tx_word(32'hDEADBEEF);
    chk("t2_data1", word_data, 32'hDEADBEEF);
    tx_word(32'h01020304);
    chk("t2_keep", word_data, 32'hDEADBEEF);
    chk("t2_valid", {31'd0, word_valid}, 32'd1);
    chk("t2_ovr", ovr_cnt, 1);
    tx(8'h11, 1'b1);
    tx(8'h22, 1'b1);
    tx(8'h33, 1'b1);
    tx(8'h44, 1'b1);
    fork
      tx(8'h0A, 1'b1);
      begin
        repeat (155) @(negedge clk);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        chk("t2_sim_valid", {31'd0, word_valid}, 32'd1);
        chk("t2_sim_data", word_data, 32'h11223344);
      end
    join
    chk("t2_ovr_once", ovr_cnt, 1);
    chk("t2_ferr", ferr_cnt, 0);
    ack();

    // 3: early terminator
    tx(8'h12, 1'b1);
    tx(8'h34, 1'b1);
    tx(8'h0A, 1'b1);
    chk("t3_ferr", ferr_cnt, 1);
    chk("t3_novalid", {31'd0, word_valid}, 32'd0);
    tx_word(32'h12345678);
    chk("t3_data", word_data, 32'h12345678);
    chk("t3_valid", {31'd0, word_valid}, 32'd1);
    ack();

    // 4: missing terminator, then lone terminator
    tx(8'h12, 1'b1);
    tx(8'h34, 1'b1);
    tx(8'h56, 1'b1);
    tx(8'h78, 1'b1);
    tx(8'h55, 1'b1);
    chk("t4_ferr1", ferr_cnt, 2);
    chk("t4_novalid", {31'd0, word_valid}, 32'd0);
    tx(8'h0A, 1'b1);
    chk("t4_ferr2", ferr_cnt, 3);
    tx_word(32'hAABBCCDD);
    chk("t4_data", word_data, 32'hAABBCCDD);
    ack();

    // 5: bad stop bit, line held low, recovery
    tx(8'h01, 1'b1);
    tx(8'h23, 1'b0);
    rx_serial = 1'b0;
    repeat (40) @(negedge clk);
    rx_serial = 1'b1;
    repeat (20) @(negedge clk);
    chk("t5_ferr", ferr_cnt, 4);
    chk("t5_novalid", {31'd0, word_valid}, 32'd0);
    tx_word(32'h01234567);
    chk("t5_data", word_data, 32'h01234567);
    chk("t5_ferr_after", ferr_cnt, 4);
    ack();

    // 6: idle glitch, then reset mid-word
    rx_serial = 1'b0;
    repeat (5) @(negedge clk);
    rx_serial = 1'b1;
    repeat (30) @(negedge clk);
    chk("t6_glitch_ferr", ferr_cnt, 4);
    chk("t6_glitch_valid", {31'd0, word_valid}, 32'd0);
    tx(8'h11, 1'b1);
    tx(8'h22, 1'b1);
    rx_serial = 1'b0;
    repeat (40) @(negedge clk);
    rst_n     = 1'b0;
    rx_serial = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_rst_data", word_data, 32'd0);
    chk("t6_rst_valid", {31'd0, word_valid}, 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    tx_word(32'hCAFEBABE);
    chk("t6_data", word_data, 32'hCAFEBABE);
    chk("t6_valid", {31'd0, word_valid}, 32'd1);
    chk("final_ferr", ferr_cnt, 4);
    chk("final_ovr", ovr_cnt, 1);
    chk("final_both", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
